// File: rtl/fft_output_serializer.sv
`default_nettype none
// ============================================================================
// Module      : fft_output_serializer
// Description : Captures one 32-point FFT result frame in a single cycle and
//               streams it out word by word over valid/ready, natural or
//               bit-reversed bin order.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_output_serializer #(
    parameter int p_dataBits   = 20,
    parameter int p_points     = 32,
    parameter int p_bitReverse = 0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         i_load,
    input  logic [32*p_dataBits-1:0]     i_frame,
    output logic                         o_busy,
    output logic                         o_drop,
    output logic [p_dataBits-1:0]        o_data,
    output logic [4:0]                   o_index,
    output logic                         o_valid,
    output logic                         o_last,
    input  logic                         i_ready
);

    localparam logic [4:0] c_LAST_CNT = 5'd31;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [4:0]            r_cnt;
    logic [4:0]            w_cnt_nxt;
    logic                  r_drop;
    logic                  w_drop_nxt;
    logic                  w_capture;
    logic                  w_stream;
    logic                  w_xfer;
    logic                  w_final;
    logic [4:0]            w_rev;
    logic [4:0]            w_idx;
    logic [p_dataBits-1:0] r_buf [0:p_points-1];

    assign w_stream = (r_state == S_STREAM);
    assign w_xfer   = w_stream & i_ready;
    assign w_final  = w_xfer & (r_cnt == c_LAST_CNT);

    generate
        for (genvar g = 0; g < 5; g++) begin : g_rev
            assign w_rev[g] = r_cnt[4-g];
        end
        if (p_bitReverse != 0) begin : g_idx_rev
            assign w_idx = w_rev;
        end else begin : g_idx_nat
            assign w_idx = r_cnt;
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    // A new frame is taken when idle, or on the very edge the old one finishes.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_drop_nxt  = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_load) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = 5'd0;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_final) begin
                    w_cnt_nxt = 5'd0;
                    if (i_load) begin
                        w_capture = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    if (w_xfer) begin
                        w_cnt_nxt = r_cnt + 5'd1;
                    end
                    w_drop_nxt = i_load;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 5'd0;
            end
        endcase
    end

    // Buffer has no reset: its contents are only observed while streaming.
    always_ff @(posedge CLK) begin
        if (w_capture) begin
            for (int k = 0; k < p_points; k++) begin
                r_buf[k] <= i_frame[k*p_dataBits +: p_dataBits];
            end
        end
    end

    assign o_valid = w_stream;
    assign o_busy  = w_stream;
    assign o_drop  = r_drop;
    assign o_last  = w_stream & (r_cnt == c_LAST_CNT);
    assign o_index = w_stream ? w_idx : 5'd0;
    assign o_data  = w_stream ? r_buf[w_idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_fft_output_serializer.sv
`default_nettype none
// Bench for fft_output_serializer: a natural-order and a bit-reversed instance
// share stimulus and are compared against a queue-based frame model.
module tb_fft_output_serializer;

    localparam int W = 20;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          i_load = 1'b0;
    logic          i_ready = 1'b0;
    logic [32*W-1:0] i_frame = '0;

    logic          busy_n, drop_n, valid_n, last_n;
    logic [W-1:0]  data_n;
    logic [4:0]    index_n;
    logic          busy_r, drop_r, valid_r, last_r;
    logic [W-1:0]  data_r;
    logic [4:0]    index_r;

    fft_output_serializer #(.p_dataBits(W), .p_points(32), .p_bitReverse(0)) dut_n (
        .CLK(CLK), .RST(RST), .i_load(i_load), .i_frame(i_frame),
        .o_busy(busy_n), .o_drop(drop_n), .o_data(data_n), .o_index(index_n),
        .o_valid(valid_n), .o_last(last_n), .i_ready(i_ready)
    );

    fft_output_serializer #(.p_dataBits(W), .p_points(32), .p_bitReverse(1)) dut_r (
        .CLK(CLK), .RST(RST), .i_load(i_load), .i_frame(i_frame),
        .o_busy(busy_r), .o_drop(drop_r), .o_data(data_r), .o_index(index_r),
        .o_valid(valid_r), .o_last(last_r), .i_ready(i_ready)
    );

    always #5 CLK = ~CLK;

    int            n_vec = 0;
    int            n_err = 0;
    logic [W-1:0]  cur [32];
    logic [W-1:0]  m_frame [32];
    int            q [$];
    logic          m_drop = 1'b0;

    function automatic int brev5(input int v);
        int r = 0;
        for (int b = 0; b < 5; b++) begin
            r = r * 2 + ((v >> b) % 2);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // kind 0: 3k+1, 1: F0000|k, 2: 80000+k, 3: random words
    task automatic set_frame(input int kind);
        for (int k = 0; k < 32; k++) begin
            case (kind)
                0:       cur[k] = W'(3 * k + 1);
                1:       cur[k] = 20'hF0000 | W'(k);
                2:       cur[k] = 20'h80000 + W'(k);
                default: cur[k] = W'($urandom);
            endcase
            i_frame[k*W +: W] = cur[k];
        end
    endtask

    task automatic check_outs();
        int p;
        int br;
        chk("valid_n", 32'(valid_n), 32'(q.size() > 0));
        chk("valid_r", 32'(valid_r), 32'(q.size() > 0));
        chk("busy_n",  32'(busy_n),  32'(q.size() > 0));
        chk("busy_r",  32'(busy_r),  32'(q.size() > 0));
        chk("drop_n",  32'(drop_n),  32'(m_drop));
        chk("drop_r",  32'(drop_r),  32'(m_drop));
        if (q.size() > 0) begin
            p  = q[0];
            br = brev5(p);
            chk("index_n", 32'(index_n), 32'(p));
            chk("data_n",  32'(data_n),  32'(m_frame[p]));
            chk("last_n",  32'(last_n),  32'(p == 31));
            chk("index_r", 32'(index_r), 32'(br));
            chk("data_r",  32'(data_r),  32'(m_frame[br]));
            chk("last_r",  32'(last_r),  32'(br == 31));
        end else begin
            chk("last_n_idle", 32'(last_n), 32'd0);
            chk("last_r_idle", 32'(last_r), 32'd0);
        end
    endtask

    // One clock: apply inputs, advance the model across the edge, check after it.
    task automatic cycle(input logic ld, input logic rdy);
        logic xfer;
        logic accept;
        i_load  = ld;
        i_ready = rdy;
        xfer    = (q.size() > 0) && rdy;
        accept  = ld && ((q.size() == 0) || (xfer && q.size() == 1));
        @(posedge CLK);
        #1;
        if (xfer) void'(q.pop_front());
        if (accept) begin
            for (int k = 0; k < 32; k++) begin
                m_frame[k] = cur[k];
                q.push_back(k);
            end
        end
        m_drop  = ld && !accept;
        i_load  = 1'b0;
        check_outs();
    endtask

    task automatic run_until(input int remaining, input logic random_ready);
        for (int c = 0; c < 400 && q.size() > remaining; c++) begin
            cycle(1'b0, random_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_valid"}, {30'd0, valid_n, valid_r}, 32'd0);
        chk({tag, "_busy"},  {30'd0, busy_n, busy_r},   32'd0);
        chk({tag, "_drop"},  {30'd0, drop_n, drop_r},   32'd0);
        chk({tag, "_last"},  {30'd0, last_n, last_r},   32'd0);
        chk({tag, "_data"},  32'(data_n | data_r),      32'd0);
        chk({tag, "_index"}, 32'(index_n | index_r),    32'd0);
    endtask

    initial begin
        // Reset state
        #2;
        check_reset_outs("rst");
        @(negedge CLK);
        RST = 1'b0;

        // Full frame at full throughput, 3k+1 pattern
        set_frame(0);
        cycle(1'b1, 1'b1);
        run_until(0, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);

        // Random backpressure, F0000|k pattern
        set_frame(1);
        cycle(1'b1, 1'($urandom_range(0, 1)));
        run_until(0, 1'b1);
        cycle(1'b0, 1'b1);

        // Load rejected during word 10 of frame A
        set_frame(0);
        cycle(1'b1, 1'b1);
        run_until(22, 1'b0);
        set_frame(2);
        cycle(1'b1, 1'b1);
        run_until(0, 1'b0);
        cycle(1'b0, 1'b1);

        // Back-to-back: B loaded on A's final transfer
        set_frame(0);
        cycle(1'b1, 1'b1);
        run_until(1, 1'b0);
        set_frame(2);
        cycle(1'b1, 1'b1);
        run_until(0, 1'b1);
        cycle(1'b0, 1'b1);

        // Random frames, random stalls, loads attempted at random
        for (int f = 0; f < 3; f++) begin
            set_frame(3);
            cycle(1'b1, 1'($urandom_range(0, 1)));
            for (int c = 0; c < 120 && q.size() > 0; c++) begin
                if (($urandom % 16) == 0) set_frame(3);
                cycle(1'(($urandom % 8) == 0), 1'($urandom_range(0, 1)));
            end
        end
        run_until(0, 1'b0);
        cycle(1'b0, 1'b1);

        // Asynchronous reset during word 17
        set_frame(1);
        cycle(1'b1, 1'b1);
        run_until(15, 1'b0);
        i_ready = 1'b0;
        #3;
        RST = 1'b1;
        #1;
        check_reset_outs("async_rst");
        q.delete();
        m_drop = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        set_frame(3);
        cycle(1'b1, 1'b1);
        run_until(0, 1'b1);
        cycle(1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_output_serializer.md
Name: fft_output_serializer

Overview:
- Reader side of the 32-point FFT datapath: captures the 32 parallel results of the final butterfly stage (X0..X31) in a single cycle.
- Streams the captured results out one word per transfer over a valid/ready interface, in natural or bit-reversed index order.
- Sits between the last FFT stage and the downstream consumer (DMA/UART/testbench sink). Frees the stage outputs for the next frame once captured.

Parameters:
- p_dataBits, 20, width of each FFT result word (matches stage output width)
- p_points, 32, number of results per frame; fixed at 32, index width 5
- p_bitReverse, 0, 0 = emit X0,X1..X31; 1 = emit element at bit-reversed index (X0,X16,X8..X31)

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  reset, asynchronous, active-high
- i_load  input  1  one-cycle strobe: i_frame holds a valid frame to capture
- i_frame  input  32*p_dataBits  flattened results; X[k] at bits [k*p_dataBits +: p_dataBits]
- o_busy  output  1  high while a frame is held or streaming; capture only when low or freeing this cycle
- o_drop  output  1  one-cycle pulse: i_load was rejected
- o_data  output  p_dataBits  current result word
- o_index  output  5  FFT bin index of o_data (X index, not stream position)
- o_valid  output  1  o_data/o_index/o_last are valid
- o_last  output  1  current word is the 32nd of the frame
- i_ready  input  1  consumer accepts the word when o_valid & i_ready

Behaviour:
- Reset (async, RST=1): state IDLE; stream counter 0; o_valid 0, o_busy 0, o_drop 0, o_last 0, o_data 0, o_index 0. Frame buffer contents are don't-care.
- Storage is 32 x p_dataBits registers, single bank. Stream counter cnt[4:0]. Emitted index = cnt when p_bitReverse=0, otherwise the 5-bit reverse of cnt.
- States:
  - IDLE: o_valid=0, o_busy=0. If i_load: capture all 32 words, cnt<=0, go to STREAM.
  - STREAM: o_valid=1, o_busy=1. o_data = buf[idx], o_index = idx, o_last = (cnt==31).
- Latency: i_load sampled high at edge t gives o_valid=1 with bin 0 from edge t onward, i.e. valid in the cycle after the load cycle.
- Handshake:
  - Transfer occurs on an edge where o_valid & i_ready.
  - While o_valid=1 and i_ready=0, o_data/o_index/o_last hold stable.
  - o_valid never drops without a transfer, except on reset.
  - i_ready is don't-care in IDLE.
- Advance: on transfer with cnt<31, cnt<=cnt+1.
- End of frame: on transfer with cnt==31, go to IDLE and cnt wraps to 0, unless i_load is also high.
- Simultaneous last transfer and i_load: the new frame is captured, cnt<=0, state stays STREAM with o_valid continuously high (back-to-back frames, zero bubble). o_drop stays 0.
- i_load in STREAM, not on the final transfer: frame ignored, buffer unchanged, o_drop=1 for exactly one cycle (registered, visible the cycle after). Streaming continues unaffected.
- Data is passed through bit-exact: no scaling, rounding or sign change. Words are treated as opaque.
- o_drop is registered and cleared every cycle it is not set.
- RST mid-stream: outputs go to reset values immediately. The partial frame is discarded and the first i_load after release starts a fresh frame at bin 0.
- All outputs are registered or decoded from registered state/buffer only. There is no combinational path from i_ready or i_load to any output.

Test Plan:
- Load frame X[k]=k*3+1 (20-bit), p_bitReverse=0, i_ready tied 1 -> o_valid high for exactly 32 consecutive cycles starting the cycle after i_load; o_index 0..31 and o_data 1,4,7..94; o_last only with index 31; then o_valid=0, o_busy=0.
- Same frame, p_bitReverse=1 -> index sequence 0,16,8,24,4,20..15,31; o_data = 3*index+1 for each word; o_last on index 31.
- Random i_ready (about 50% duty) with frame X[k]=20'hF0000|k -> o_data/o_index stay stable through every stall; all 32 words are received in order with no duplicates or gaps.
- i_load pulsed with frame B (X[k]=20'h80000+k) during stream word 10 of frame A -> o_drop pulses once; the remaining words are still frame A values; B never appears.
- i_load with frame B asserted in the same cycle as frame A's word 31 transfer -> no o_valid gap; the next word is B bin 0 (20'h80000); o_drop stays 0.
- RST asserted asynchronously mid-cycle during word 17 -> o_valid, o_busy, o_data fall to 0 without a clock edge; after release, a new i_load streams from bin 0.
